// File: rtl/vga_sync_receiver_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_receiver_if
// Description : Sync inputs and recovered timing outputs of the VGA sync
//               receiver. The master is the sync source/consumer side. The
//               slave is the receiver.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_sync_receiver_if;
  logic       hsync_in;
  logic       vsync_in;
  logic [9:0] col_count;
  logic [9:0] row_count;
  logic       active_video;
  logic       frame_start;
  logic       locked;

  modport master (
    output hsync_in, vsync_in,
    input  col_count, row_count, active_video, frame_start, locked
  );

  modport slave (
    input  hsync_in, vsync_in,
    output col_count, row_count, active_video, frame_start, locked
  );
endinterface
`default_nettype wire

// File: rtl/vga_sync_receiver.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_receiver
// Description : Rebuilds column/row counters from incoming HSync/VSync. It
//               checks the line and frame periods and reports lock once the
//               timing matches the configured geometry.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_receiver #(
  parameter int TOTAL_COL  = 800,
  parameter int TOTAL_ROW  = 525,
  parameter int ACTIVE_COL = 640,
  parameter int ACTIVE_ROW = 480,
  parameter int H_SYNC_COL = 660,
  parameter int V_SYNC_ROW = 491,
  parameter int LOCK_LINES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vga_sync_receiver_if.slave   sync_if
);

  localparam logic [9:0]  C_COL_LAST   = 10'(TOTAL_COL - 1);
  localparam logic [9:0]  C_ROW_LAST   = 10'(TOTAL_ROW - 1);
  localparam logic [9:0]  C_ROW_TOTAL  = 10'(TOTAL_ROW);
  localparam logic [9:0]  C_ACT_COL    = 10'(ACTIVE_COL);
  localparam logic [9:0]  C_ACT_ROW    = 10'(ACTIVE_ROW);
  localparam logic [9:0]  C_H_SYNC     = 10'(H_SYNC_COL);
  localparam logic [9:0]  C_V_SYNC     = 10'(V_SYNC_ROW);
  localparam logic [10:0] C_LINE_GOOD  = 11'(TOTAL_COL - 1);
  localparam logic [10:0] C_LEN_MAX    = 11'h7FF;
  localparam logic [10:0] C_LEN_LOST   = 11'h7FE;
  localparam logic [9:0]  C_CNT_MAX    = 10'h3FF;
  localparam logic [3:0]  C_LOCK_LINES = 4'(LOCK_LINES);

  localparam logic [1:0] S_SEARCH  = 2'd0;
  localparam logic [1:0] S_H_LOCK  = 2'd1;
  localparam logic [1:0] S_V_ALIGN = 2'd2;
  localparam logic [1:0] S_LOCKED  = 2'd3;

  logic        hs_q, vs_q;
  logic [9:0]  col_q, col_d, row_q, row_d;
  logic [10:0] line_len_q, line_len_d;
  logic [3:0]  good_lines_q, good_lines_d;
  logic [9:0]  line_cnt_q, line_cnt_d;
  logic [1:0]  state_q, state_d;
  logic        locked_q, locked_d;

  logic w_h_fall, w_v_fall, w_col_wrap;
  logic w_good_line, w_bad_line, w_good_frame;

  assign w_h_fall     = hs_q & ~sync_if.hsync_in;
  assign w_v_fall     = vs_q & ~sync_if.vsync_in;
  assign w_col_wrap   = (col_q == C_COL_LAST);
  assign w_good_line  = w_h_fall && (line_len_q == C_LINE_GOOD);
  // A wrong-length line, or a line that runs to saturation (sync lost).
  assign w_bad_line   = (w_h_fall && !w_good_line) ||
                        (!w_h_fall && (line_len_q >= C_LEN_LOST));
  assign w_good_frame = w_v_fall && (line_cnt_q == C_ROW_TOTAL);

  // Counter recovery: sync falls snap the counters. Otherwise they free-run with wrap.
  always_comb begin
    col_d = col_q + 10'd1;
    row_d = row_q;
    if (w_h_fall) begin
      col_d = C_H_SYNC;
    end else if (w_col_wrap) begin
      col_d = 10'd0;
      row_d = (row_q == C_ROW_LAST) ? 10'd0 : row_q + 10'd1;
    end
    if (w_v_fall) begin
      row_d = C_V_SYNC;
    end
  end

  // Line/frame period measurement next values.
  always_comb begin
    line_len_d = w_h_fall ? 11'd0 :
                 (line_len_q == C_LEN_MAX) ? line_len_q : line_len_q + 11'd1;
    good_lines_d = good_lines_q;
    if (w_bad_line) begin
      good_lines_d = 4'd0;
    end else if (w_good_line && (good_lines_q != C_LOCK_LINES)) begin
      good_lines_d = good_lines_q + 4'd1;
    end
    line_cnt_d = line_cnt_q;
    if (w_v_fall) begin
      line_cnt_d = 10'd0;
    end else if (w_h_fall && (line_cnt_q != C_CNT_MAX)) begin
      line_cnt_d = line_cnt_q + 10'd1;
    end
  end

  // Datapath registers: sync delay, counters and period measurement.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
      col_q        <= 10'd0;
      row_q        <= 10'd0;
      line_len_q   <= 11'd0;
      good_lines_q <= 4'd0;
      line_cnt_q   <= 10'd0;
    end else begin
      hs_q         <= sync_if.hsync_in;
      vs_q         <= sync_if.vsync_in;
      col_q        <= col_d;
      row_q        <= row_d;
      line_len_q   <= line_len_d;
      good_lines_q <= good_lines_d;
      line_cnt_q   <= line_cnt_d;
    end
  end

  // FSM state register, with lock flag registered alongside it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_SEARCH;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      locked_q <= locked_d;
    end
  end

  // FSM next state. A bad line forces a fresh search from any state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SEARCH:  if (good_lines_d == C_LOCK_LINES) state_d = S_H_LOCK;
      S_H_LOCK:  if (w_v_fall) state_d = S_V_ALIGN;
      S_V_ALIGN: if (w_good_frame) state_d = S_LOCKED;
      S_LOCKED:  if (w_v_fall && !w_good_frame) state_d = S_SEARCH;
      default:   state_d = S_SEARCH;
    endcase
    if (w_bad_line && (state_q != S_SEARCH)) begin
      state_d = S_SEARCH;
    end
  end

  // FSM output. The lock flag tracks the state being entered, so it equals (state == LOCKED).
  always_comb begin
    locked_d = (state_d == S_LOCKED);
  end

  assign sync_if.col_count    = col_q;
  assign sync_if.row_count    = row_q;
  assign sync_if.locked       = locked_q;
  assign sync_if.active_video = locked_q && (col_q < C_ACT_COL) && (row_q < C_ACT_ROW);
  assign sync_if.frame_start  = locked_q && (col_q == 10'd0) && (row_q == 10'd0);

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_sync_receiver
// Description : Self-checking bench for vga_sync_receiver on a reduced
//               40x30 geometry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_receiver;
  localparam int TC = 40;
  localparam int TR = 30;
  localparam int AC = 32;
  localparam int AR = 24;
  localparam int HS = 34;
  localparam int VS = 27;
  localparam int LL = 4;
  localparam int HW = 4;

  logic clk;
  logic rst_n;
  vga_sync_receiver_if vif();

  vga_sync_receiver #(
    .TOTAL_COL(TC), .TOTAL_ROW(TR), .ACTIVE_COL(AC), .ACTIVE_ROW(AR),
    .H_SYNC_COL(HS), .V_SYNC_ROW(VS), .LOCK_LINES(LL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sync_if(vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int fs_cnt = 0;
  int av_cnt = 0;

  // Reference model state, in terms of sync events and measured periods.
  int m_col, m_row, m_len, m_good, m_lines, m_phase;
  bit m_hs, m_vs, m_lock;
  localparam int PH_SEARCH = 0, PH_HOK = 1, PH_ALIGN = 2, PH_LOCK = 3;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rn, input bit h, input bit v);
    bit hf, vf, line_ok, bad, frame_ok;
    if (!rn) begin
      m_col = 0; m_row = 0; m_len = 0; m_good = 0; m_lines = 0;
      m_phase = PH_SEARCH; m_hs = 1; m_vs = 1; m_lock = 0;
      return;
    end
    hf = m_hs && !h;
    vf = m_vs && !v;
    m_hs = h;
    m_vs = v;
    // Line of exactly TC clocks: TC-1 clocks elapsed since the previous fall.
    line_ok  = hf && (m_len == TC - 1);
    bad      = (hf && !line_ok) || (!hf && m_len + 1 >= 2047);
    frame_ok = vf && (m_lines == TR);
    if (!hf && m_col == TC - 1) m_row = (m_row + 1) % TR;
    if (vf) m_row = VS;
    m_col = hf ? HS : (m_col + 1) % TC;
    m_len = hf ? 0 : ((m_len + 1 > 2047) ? 2047 : m_len + 1);
    if (bad) m_good = 0;
    else if (line_ok) m_good = (m_good + 1 > LL) ? LL : m_good + 1;
    if (vf) m_lines = 0;
    else if (hf) m_lines = (m_lines + 1 > 1023) ? 1023 : m_lines + 1;
    if (bad && m_phase != PH_SEARCH) m_phase = PH_SEARCH;
    else if (m_phase == PH_SEARCH && m_good >= LL) m_phase = PH_HOK;
    else if (m_phase == PH_HOK && vf) m_phase = PH_ALIGN;
    else if (m_phase == PH_ALIGN && frame_ok) m_phase = PH_LOCK;
    else if (m_phase == PH_LOCK && vf && !frame_ok) m_phase = PH_SEARCH;
    m_lock = (m_phase == PH_LOCK);
  endtask

  // One clock: sample after the edge, advance the model, compare all outputs.
  task automatic tick();
    int act, exp;
    bit e_av, e_fs;
    @(posedge clk);
    #1;
    model_step(rst_n, vif.hsync_in, vif.vsync_in);
    e_av = m_lock && (m_col < AC) && (m_row < AR);
    e_fs = m_lock && (m_col == 0) && (m_row == 0);
    act = int'({vif.col_count, vif.row_count, vif.active_video, vif.frame_start, vif.locked});
    exp = int'({10'(m_col), 10'(m_row), e_av, e_fs, m_lock});
    check("model_outputs", act, exp);
    fs_cnt += int'(vif.frame_start);
    av_cnt += int'(vif.active_video);
  endtask

  task automatic gen_pix(input int c, input int r);
    vif.hsync_in = !(c >= HS && c < HS + HW);
    vif.vsync_in = !(r == VS);
    tick();
  endtask

  task automatic gen_line(input int r, input int len);
    for (int c = 0; c < len; c++) gen_pix(c, r);
  endtask

  task automatic gen_rows(input int first, input int last, input int stretch_row);
    for (int r = first; r < last; r++) gen_line(r, (r == stretch_row) ? TC + 1 : TC);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    vif.hsync_in = 1'b1;
    vif.vsync_in = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit rn;
    bit h;
    bit v;
    int col;
    int row;
    bit lk;
  } vec_t;
  vec_t tbl [12];

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 0,  0,      1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1,  0,      1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 2,  0,      1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, HS, 0,      1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, HS + 1, 0,  1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, HS + 2, 0,  1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, HS + 3, VS, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, HS + 4, VS, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, HS + 5, VS, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 0,  VS + 1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, HS, VS,     1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 0,  0,      1'b0};

    rst_n = 1'b0;
    vif.hsync_in = 1'b1;
    vif.vsync_in = 1'b1;

    // Reset, edge detection, wrap and simultaneous sync falls.
    for (int i = 0; i < 12; i++) begin
      rst_n = tbl[i].rn;
      vif.hsync_in = tbl[i].h;
      vif.vsync_in = tbl[i].v;
      tick();
      check("vec_col", int'(vif.col_count), tbl[i].col);
      check("vec_row", int'(vif.row_count), tbl[i].row);
      check("vec_locked", int'(vif.locked), int'(tbl[i].lk));
    end

    // Nominal timing: lock after the second vsync fall.
    do_reset();
    gen_rows(0, TR, -1);
    check("no_early_lock", int'(vif.locked), 0);
    gen_rows(0, TR, -1);
    check("lock_nominal", int'(vif.locked), 1);
    fs_cnt = 0;
    av_cnt = 0;
    gen_rows(0, TR, -1);
    check("frame_start_per_frame", fs_cnt, 1);
    check("active_per_frame", av_cnt, AC * AR);

    // Stretched line drops lock, then relock.
    gen_rows(0, TR, 5);
    check("stretch_unlock", int'(vif.locked), 0);
    gen_rows(0, TR, -1);
    check("stretch_relock", int'(vif.locked), 1);

    // Sync lost: hsync held high until the line length saturates.
    vif.hsync_in = 1'b1;
    vif.vsync_in = 1'b1;
    for (int i = 0; i < 2000; i++) tick();
    check("hold_still_locked", int'(vif.locked), 1);
    for (int i = 0; i < 100; i++) tick();
    check("hold_unlock", int'(vif.locked), 0);
    gen_rows(0, TR, -1);
    gen_rows(0, TR, -1);
    check("hold_relock", int'(vif.locked), 1);

    // Short frame: lock drops at the v_fall closing the short period.
    gen_rows(0, TR - 1, -1);
    gen_rows(0, VS, -1);
    gen_pix(0, VS);
    check("short_frame_unlock", int'(vif.locked), 0);
    check("short_frame_row", int'(vif.row_count), VS);
    for (int c = 1; c < TC; c++) gen_pix(c, VS);
    gen_rows(VS + 1, TR, -1);
    gen_rows(0, TR, -1);
    gen_rows(0, TR, -1);
    check("short_frame_relock", int'(vif.locked), 1);

    // One-clock reset while locked, mid-frame.
    gen_rows(0, 10, -1);
    rst_n = 1'b0;
    tick();
    check("rst_col", int'(vif.col_count), 0);
    check("rst_row", int'(vif.row_count), 0);
    check("rst_locked", int'(vif.locked), 0);
    check("rst_active", int'(vif.active_video), 0);
    check("rst_fstart", int'(vif.frame_start), 0);
    rst_n = 1'b1;
    gen_rows(10, TR, -1);
    gen_rows(0, TR, -1);
    check("rst_relock", int'(vif.locked), 1);

    // Randomized timing perturbations against the model.
    for (int f = 0; f < 20; f++) begin
      int nl;
      nl = TR;
      if ($urandom_range(0, 5) == 0) nl = ($urandom_range(0, 1) == 0) ? TR - 1 : TR + 1;
      for (int r = 0; r < nl; r++) begin
        int len;
        len = TC;
        if ($urandom_range(0, 15) == 0) len = ($urandom_range(0, 1) == 0) ? TC - 1 : TC + 1;
        gen_line(r, len);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
